alu_mdu: RTL and testbench

Parametrised, registered successor to the single-cycle integer ALU. It executes the existing ALU operation set with corrected signed compare and true arithmetic shift, and adds iterative multiply/divide into internal HI/LO registers. A valid/ready input handshake and a registered result pulse connect it to the execute stage. The stage stalls on `in_ready` while a multiply or divide is in flight.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/muldiv_iter.sv | 150 +++++++++++++++
 rtl/alu_mdu.sv | 121 ++++++++++++
 tb/tb_alu_mdu.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the registered ALU with iterative multiply/divide:
// operation codes, sequencer states and result-flag bit positions.
package alu_pkg;

   typedef enum logic [4:0] {
      OP_ADD   = 5'd0,
      OP_ADDU  = 5'd1,
      OP_SUB   = 5'd2,
      OP_SUBU  = 5'd3,
      OP_AND   = 5'd4,
      OP_OR    = 5'd5,
      OP_NOR   = 5'd6,
      OP_SLT   = 5'd7,
      OP_SLL   = 5'd8,
      OP_SRL   = 5'd9,
      OP_SRA   = 5'd10,
      OP_JR    = 5'd11,
      OP_NOP   = 5'd12,
      OP_MULT  = 5'd13,
      OP_MULTU = 5'd14,
      OP_DIV   = 5'd15,
      OP_DIVU  = 5'd16,
      OP_MFHI  = 5'd17,
      OP_MFLO  = 5'd18,
      OP_SLTU  = 5'd19
   } op_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } state_t;

   localparam int FLAG_OVF = 0;
   localparam int FLAG_DZ  = 1;
   localparam int FLAG_ILL = 2;
   localparam int FLAG_W   = 3;

   function automatic logic is_muldiv(input logic [4:0] op);
      return (op >= OP_MULT) && (op <= OP_DIVU);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative radix-2 multiplier / restoring divider working on operand magnitudes,
// with a two-cycle FIX phase that applies the sign correction and reports completion.
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             dz
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   acc_hi;
   logic [WIDTH-1:0]   acc_lo;
   logic [WIDTH-1:0]   opnd;
   logic               neg_q;
   logic               neg_r;
   logic               is_div;
   logic               dz_reg;
   logic               fix_hold;

   logic               is_signed;
   logic               sign_a;
   logic               sign_b;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic               start_div;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_shift;
   logic [WIDTH:0]     div_diff;
   logic [2*WIDTH-1:0] prod;

   always_comb begin
      is_signed = (op == OP_MULT) || (op == OP_DIV);
      start_div = (op == OP_DIV) || (op == OP_DIVU);
      sign_a    = is_signed & a[WIDTH-1];
      sign_b    = is_signed & b[WIDTH-1];
      mag_a     = sign_a ? -a : a;
      mag_b     = sign_b ? -b : b;

      // Multiply: acc_lo holds the remaining multiplier bits, product shifts in from the top.
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});

      // Divide: shift the next dividend bit into the remainder and try a subtract.
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
   end

   always_comb begin
      prod = {acc_hi, acc_lo};
      if (neg_q) begin
         prod = -prod;
      end
      hi = prod[2*WIDTH-1:WIDTH];
      lo = prod[WIDTH-1:0];
      if (is_div) begin
         lo = neg_q ? -acc_lo : acc_lo;
         hi = neg_r ? -acc_hi : acc_hi;
         // With a zero divisor the remainder path already reproduces the dividend.
         if (dz_reg) begin
            lo = {WIDTH{1'b1}};
         end
      end
   end

   assign busy = (state != IDLE);
   assign done = (state == FIX) && !fix_hold;
   assign dz   = dz_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         cnt      <= '0;
         acc_hi   <= '0;
         acc_lo   <= '0;
         opnd     <= '0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         is_div   <= 1'b0;
         dz_reg   <= 1'b0;
         fix_hold <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  cnt      <= CNT_W'(WIDTH - 1);
                  fix_hold <= 1'b0;
                  acc_hi   <= '0;
                  neg_q    <= sign_a ^ sign_b;
                  is_div   <= start_div;
                  if (start_div) begin
                     acc_lo <= mag_a;
                     opnd   <= mag_b;
                     neg_r  <= sign_a;
                     dz_reg <= (b == '0);
                     state  <= DIV;
                  end else begin
                     acc_lo <= mag_b;
                     opnd   <= mag_a;
                     neg_r  <= 1'b0;
                     dz_reg <= 1'b0;
                     state  <= MUL;
                  end
               end
            end
            MUL: begin
               acc_hi <= mul_sum[WIDTH:1];
               acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
               if (cnt == '0) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DIV: begin
               acc_hi <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
               acc_lo <= {acc_lo[WIDTH-2:0], ~div_diff[WIDTH]};
               if (cnt == '0) begin
                  state <= FIX;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            FIX: begin
               // First FIX cycle publishes the result; the second keeps the stage stalled
               // through the strobe cycle.
               if (!fix_hold) begin
                  fix_hold <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/alu_mdu.sv
// Registered integer ALU with HI/LO registers, valid/ready input handshake and a
// one-cycle result strobe; multiply/divide are delegated to the iterative unit.
module alu_mdu
   import alu_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [4:0]         op_code,
   input  logic [WIDTH-1:0]   reg1,
   input  logic [WIDTH-1:0]   reg2,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   output logic [WIDTH-1:0]   result,
   output logic               ovf,
   output logic               div_zero,
   output logic               illegal
);

   logic [WIDTH-1:0]  hi_reg;
   logic [WIDTH-1:0]  lo_reg;
   logic [WIDTH-1:0]  alu_res;
   logic [FLAG_W-1:0] alu_flags;
   logic [WIDTH-1:0]  sum;
   logic [WIDTH-1:0]  diff;
   logic              accept;
   logic              md_start;
   logic              md_busy;
   logic              md_done;
   logic [WIDTH-1:0]  md_hi;
   logic [WIDTH-1:0]  md_lo;
   logic              md_dz;

   assign in_ready = ~md_busy;
   assign accept   = in_valid & in_ready;
   assign md_start = accept & is_muldiv(op_code);

   always_comb begin
      sum       = reg1 + reg2;
      diff      = reg1 - reg2;
      alu_res   = '0;
      alu_flags = '0;
      case (op_code)
         OP_ADD: begin
            alu_res             = sum;
            alu_flags[FLAG_OVF] = (reg1[WIDTH-1] == reg2[WIDTH-1]) && (sum[WIDTH-1] != reg1[WIDTH-1]);
         end
         OP_ADDU: alu_res = sum;
         OP_SUB: begin
            alu_res             = diff;
            alu_flags[FLAG_OVF] = (reg1[WIDTH-1] != reg2[WIDTH-1]) && (diff[WIDTH-1] != reg1[WIDTH-1]);
         end
         OP_SUBU:  alu_res = diff;
         OP_AND:   alu_res = reg1 & reg2;
         OP_OR:    alu_res = reg1 | reg2;
         OP_NOR:   alu_res = ~(reg1 | reg2);
         OP_SLT:   alu_res = {{(WIDTH-1){1'b0}}, ($signed(reg1) < $signed(reg2))};
         OP_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, (reg1 < reg2)};
         OP_SLL:   alu_res = reg2 << shamt;
         OP_SRL:   alu_res = reg2 >> shamt;
         OP_SRA:   alu_res = $signed(reg2) >>> shamt;
         OP_JR:    alu_res = reg1;
         OP_NOP:   alu_res = '0;
         OP_MFHI:  alu_res = hi_reg;
         OP_MFLO:  alu_res = lo_reg;
         OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: alu_res = '0;
         default:  alu_flags[FLAG_ILL] = 1'b1;
      endcase
   end

   muldiv_iter #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clk   (clk),
      .rst_n (rst_n),
      .start (md_start),
      .op    (op_code),
      .a     (reg1),
      .b     (reg2),
      .busy  (md_busy),
      .done  (md_done),
      .hi    (md_hi),
      .lo    (md_lo),
      .dz    (md_dz)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         result    <= '0;
         ovf       <= 1'b0;
         div_zero  <= 1'b0;
         illegal   <= 1'b0;
         hi_reg    <= '0;
         lo_reg    <= '0;
      end else begin
         out_valid <= 1'b0;
         // A completion and a new accept never coincide: in_ready is low throughout FIX.
         if (md_done) begin
            hi_reg    <= md_hi;
            lo_reg    <= md_lo;
            result    <= md_lo;
            out_valid <= 1'b1;
            ovf       <= 1'b0;
            div_zero  <= md_dz;
            illegal   <= 1'b0;
         end else if (accept && !is_muldiv(op_code)) begin
            result    <= alu_res;
            out_valid <= 1'b1;
            ovf       <= alu_flags[FLAG_OVF];
            div_zero  <= alu_flags[FLAG_DZ];
            illegal   <= alu_flags[FLAG_ILL];
         end
      end
   end

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu (WIDTH=32): directed vector table, handshake and
// reset corner sequences, then random operations against a plain-arithmetic model.
module tb_alu_mdu;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  op_code = '0;
   logic [31:0] reg1 = '0;
   logic [31:0] reg2 = '0;
   logic [4:0]  shamt = '0;
   logic        out_valid;
   logic [31:0] result;
   logic        ovf;
   logic        div_zero;
   logic        illegal;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   typedef struct packed {
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  sh;
      logic [31:0] res;
      logic        ovf;
      logic        dz;
      logic        ill;
   } vec_t;

   vec_t vecs[$];

   alu_mdu #(
      .WIDTH   (32),
      .SHAMT_W (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op_code   (op_code),
      .reg1      (reg1),
      .reg2      (reg2),
      .shamt     (shamt),
      .out_valid (out_valid),
      .result    (result),
      .ovf       (ovf),
      .div_zero  (div_zero),
      .illegal   (illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Behavioural reference: architectural result straight from integer arithmetic.
   task automatic model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] sh, output logic [31:0] res, output logic ov,
                        output logic dz, output logic il);
      longint      sa, sb, s;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0; ov = 1'b0; dz = 1'b0; il = 1'b0;
      case (op)
         5'd0:  begin s = sa + sb; res = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
         5'd1:  res = a + b;
         5'd2:  begin s = sa - sb; res = s[31:0]; ov = (s != longint'($signed(s[31:0]))); end
         5'd3:  res = a - b;
         5'd4:  res = a & b;
         5'd5:  res = a | b;
         5'd6:  res = ~(a | b);
         5'd7:  res = (sa < sb) ? 32'd1 : 32'd0;
         5'd19: res = (a < b) ? 32'd1 : 32'd0;
         5'd8:  res = b << sh;
         5'd9:  res = b >> sh;
         5'd10: begin s = sb >>> sh; res = s[31:0]; end
         5'd11: res = a;
         5'd12: res = '0;
         5'd17: res = m_hi;
         5'd18: res = m_lo;
         5'd13: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; end
         5'd14: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; end
         5'd15: begin
            if (b == 0) begin m_lo = '1; m_hi = a; dz = 1'b1; end
            else begin s = sa / sb; m_lo = s[31:0]; s = sa % sb; m_hi = s[31:0]; end
            res = m_lo;
         end
         5'd16: begin
            if (b == 0) begin m_lo = '1; m_hi = a; dz = 1'b1; end
            else begin m_lo = a / b; m_hi = a % b; end
            res = m_lo;
         end
         default: il = 1'b1;
      endcase
   endtask

   // Called just after a falling edge; returns the strobed result and its latency in cycles.
   task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output logic [31:0] res, output logic ov,
                         output logic dz, output logic il, output int lat);
      int w;
      op_code = op; reg1 = a; reg2 = b; shamt = sh; in_valid = 1'b1;
      w = 0;
      while (!in_ready && w < 100) begin
         @(negedge clk);
         w++;
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!out_valid && lat < 100);
      res = result; ov = ovf; dz = div_zero; il = illegal;
      $display("[TB] op=%0d a=%h b=%h sh=%0d -> res=%h ovf=%b dz=%b ill=%b lat=%0d",
               op, a, b, sh, res, ov, dz, il, lat);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 6))
         0: return 32'h0;
         1: return 32'h1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 20));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [31:0] r, er;
      logic        o, d, il, eo, ed, eil;
      logic [4:0]  op;
      int          lat, exp_lat, acc_n, strobes;
      int          strobe_n[$];
      logic [31:0] strobe_r[$];

      vecs.push_back('{5'd0,  32'h7FFF_FFFF, 32'h1,         5'd0, 32'h8000_0000, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{5'd1,  32'h7FFF_FFFF, 32'h1,         5'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd7,  32'hFFFF_FFFF, 32'h1,         5'd0, 32'h1,         1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd19, 32'hFFFF_FFFF, 32'h1,         5'd0, 32'h0,         1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd10, 32'h0,         32'h8000_0000, 5'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd9,  32'h0,         32'h8000_0000, 5'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd13, 32'hFFFF_FFFD, 32'h5,         5'd0, 32'hFFFF_FFF1, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd17, 32'h0,         32'h0,         5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd14, 32'hFFFF_FFFF, 32'h2,         5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd17, 32'h0,         32'h0,         5'd0, 32'h1,         1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd16, 32'd100,       32'd7,         5'd0, 32'd14,        1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd17, 32'h0,         32'h0,         5'd0, 32'd2,         1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd15, 32'hFFFF_FFF9, 32'd2,         5'd0, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd17, 32'h0,         32'h0,         5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd15, 32'd5,         32'd0,         5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0});
      vecs.push_back('{5'd17, 32'h0,         32'h0,         5'd0, 32'd5,         1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd17, 32'h0,         32'h0,         5'd0, 32'h0,         1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd2,  32'h8000_0000, 32'h1,         5'd0, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0});
      vecs.push_back('{5'd6,  32'h0,         32'h0,         5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd31, 32'h1234_5678, 32'h9,         5'd0, 32'h0,         1'b0, 1'b0, 1'b1});
      vecs.push_back('{5'd18, 32'h0,         32'h0,         5'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd11, 32'hCAFE_0001, 32'h0,         5'd0, 32'hCAFE_0001, 1'b0, 1'b0, 1'b0});
      vecs.push_back('{5'd12, 32'h5555_5555, 32'h3,         5'd0, 32'h0,         1'b0, 1'b0, 1'b0});

      // Reset state
      #1;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_flags", {29'b0, ovf, div_zero, illegal}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table
      foreach (vecs[i]) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, r, o, d, il, lat);
         exp_lat = (vecs[i].op >= 5'd13 && vecs[i].op <= 5'd16) ? 34 : 1;
         chk($sformatf("vec%0d_res", i), r, vecs[i].res);
         chk($sformatf("vec%0d_flags", i), {29'b0, o, d, il}, {29'b0, vecs[i].ovf, vecs[i].dz, vecs[i].ill});
         chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(exp_lat));
      end

      // Back-to-back single-cycle ops give strobes on consecutive cycles
      @(negedge clk);
      op_code = 5'd10; reg1 = '0; reg2 = 32'h8000_0000; shamt = 5'd4; in_valid = 1'b1;
      @(posedge clk);
      #1 op_code = 5'd9;
      @(negedge clk);
      chk("b2b_first_valid", 32'(out_valid), 32'd1);
      chk("b2b_first_res", result, 32'hF800_0000);
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      chk("b2b_second_valid", 32'(out_valid), 32'd1);
      chk("b2b_second_res", result, 32'h0800_0000);
      @(negedge clk);
      chk("b2b_idle_valid", 32'(out_valid), 32'd0);
      $display("[TB] back-to-back sra/srl sequence done");

      // add held valid while a divide is in flight
      op_code = 5'd16; reg1 = 32'd100; reg2 = 32'd7; shamt = '0; in_valid = 1'b1;
      @(posedge clk);
      #1 op_code = 5'd0; reg1 = 32'd3; reg2 = 32'd4;
      acc_n = -1;
      for (int n = 1; n <= 50; n++) begin
         @(negedge clk);
         if (out_valid) begin
            strobe_n.push_back(n);
            strobe_r.push_back(result);
         end
         if (n == 34) chk("hold_ready_at_strobe", 32'(in_ready), 32'd0);
         if (in_valid && in_ready) begin
            acc_n = n;
            @(posedge clk);
            #1 in_valid = 1'b0;
         end
      end
      chk("hold_strobe_count", 32'(strobe_n.size()), 32'd2);
      chk("hold_accept_cycle", 32'(acc_n), 32'd35);
      if (strobe_n.size() >= 2) begin
         chk("hold_div_cycle", 32'(strobe_n[0]), 32'd34);
         chk("hold_div_res", strobe_r[0], 32'd14);
         chk("hold_add_cycle", 32'(strobe_n[1]), 32'd36);
         chk("hold_add_res", strobe_r[1], 32'd7);
      end
      $display("[TB] held add during divu sequence done");

      // Reset in the middle of a multiply
      @(negedge clk);
      op_code = 5'd13; reg1 = 32'd1234; reg2 = 32'hFFFF_0000; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("midrst_busy", 32'(in_ready), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("midrst_ready", 32'(in_ready), 32'd1);
      chk("midrst_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      strobes = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (out_valid) strobes++;
      end
      chk("midrst_no_strobe", 32'(strobes), 32'd0);
      m_hi = '0;
      m_lo = '0;
      run_op(5'd17, '0, '0, '0, r, o, d, il, lat);
      chk("midrst_mfhi", r, 32'd0);
      run_op(5'd18, '0, '0, '0, r, o, d, il, lat);
      chk("midrst_mflo", r, 32'd0);
      run_op(5'd31, 32'hAAAA_AAAA, 32'h5, '0, r, o, d, il, lat);
      chk("midrst_illegal_res", r, 32'd0);
      chk("midrst_illegal_flag", 32'(il), 32'd1);

      // Random operations against the reference model
      for (int i = 0; i < 40; i++) begin
         op = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(20, 31)) : 5'($urandom_range(0, 19));
         reg1 = pick();
         reg2 = pick();
         shamt = 5'($urandom_range(0, 31));
         model(op, reg1, reg2, shamt, er, eo, ed, eil);
         exp_lat = (op >= 5'd13 && op <= 5'd16) ? 34 : 1;
         run_op(op, reg1, reg2, shamt, r, o, d, il, lat);
         chk($sformatf("rnd%0d_op%0d_res", i, op), r, er);
         chk($sformatf("rnd%0d_op%0d_flags", i, op), {29'b0, o, d, il}, {29'b0, eo, ed, eil});
         chk($sformatf("rnd%0d_op%0d_lat", i, op), 32'(lat), 32'(exp_lat));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
